// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   lock_state_e      : host lock FSM states
//   CORE / HOST       : requester index into the 2-bit request/grant vectors
//   DEFAULT_*         : default widths and lock bound used by the top
package dmem_arbiter_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam int CORE = 0;
  localparam int HOST = 1;

  localparam int DEFAULT_ADDR_W   = 32;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_LOCK_MAX = 16;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (core load/store path, host/DMA
// port), the arbiter and the single-port data memory.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            stall, read return and the memory command)
//   master : environment view (requesters plus memory)
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  // core port
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [2:0]        core_funct3;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  // host port
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [2:0]        host_funct3;
  logic              host_lock;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  // memory side
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_funct3,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_funct3, host_lock,
    output host_gnt, host_rvalid, host_rdata,
    output mem_we, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_funct3,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata, host_funct3, host_lock,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_we, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker (purely combinational).
//   req[1:0] : request vector, bit CORE / bit HOST
//   prio     : 0 = CORE wins contention, 1 = HOST wins contention
//   gnt[1:0] : one-hot (or zero) grant vector
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // A lone requester always wins; prio only breaks a tie.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt[CORE] = 1'b1;
      2'b10: gnt[HOST] = 1'b1;
      2'b11: begin
        if (prio) begin
          gnt[HOST] = 1'b1;
        end else begin
          gnt[CORE] = 1'b1;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core
// load/store path and the host/DMA port.
//   clk, rst : clock and synchronous active-high reset
//   bus      : dmem_arbiter_if.slave (both request ports, grants, stall,
//              registered read return, memory command and mem_rdata)
// Grants are combinational from the live requests and registered state;
// read data is registered and returned one cycle after a granted load.
// The host may hold a lock that wins all contention, but after LOCK_MAX
// consecutive host grants a waiting core is forced one slot.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int LOCK_MAX = DEFAULT_LOCK_MAX
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZRO = CNT_W'(0);

  lock_state_e       lock_state_r;
  logic              prio_r;
  logic [CNT_W-1:0]  lock_cnt_r;
  logic              core_rvalid_r;
  logic              host_rvalid_r;
  logic [DATA_W-1:0] core_rdata_r;
  logic [DATA_W-1:0] host_rdata_r;

  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              locked_s;
  logic              unlocking_s;
  logic              forced_s;
  logic              contended_s;
  logic              pick_prio_s;
  logic              core_load_s;
  logic              host_load_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [2:0]        mem_funct3_s;

  // Requests are masked during reset so nothing is granted or stalled.
  always_comb begin
    req_s = 2'b00;
    if (rst) begin
      req_s = 2'b00;
    end else begin
      req_s[CORE] = bus.core_req;
      req_s[HOST] = bus.host_req;
    end
  end

  // Lock qualification and the priority handed to the picker this cycle.
  // A held lock makes the host win, except for the forced core slot; the
  // cycle that drops the lock is arbitrated unlocked with the core first.
  always_comb begin
    locked_s    = (lock_state_r == LOCKED) && bus.host_lock;
    unlocking_s = (lock_state_r == LOCKED) && !bus.host_lock;
    forced_s    = locked_s && (lock_cnt_r == CNT_MAX) && req_s[CORE];
    contended_s = req_s[CORE] && req_s[HOST];
    cnt_inc_s   = (lock_cnt_r == CNT_MAX) ? CNT_MAX : (lock_cnt_r + CNT_ONE);
    if (forced_s) begin
      pick_prio_s = 1'b0;
    end else if (locked_s) begin
      pick_prio_s = 1'b1;
    end else if (unlocking_s) begin
      pick_prio_s = 1'b0;
    end else begin
      pick_prio_s = prio_r;
    end
  end

  rr_pick2 u_pick (
    .req  (req_s),
    .prio (pick_prio_s),
    .gnt  (gnt_s)
  );

  // Memory command mux: the granted port drives memory, otherwise all zero.
  always_comb begin
    mem_we_s     = 1'b0;
    mem_addr_s   = '0;
    mem_wdata_s  = '0;
    mem_funct3_s = 3'b000;
    if (gnt_s[CORE]) begin
      mem_we_s     = bus.core_we;
      mem_addr_s   = bus.core_addr;
      mem_wdata_s  = bus.core_wdata;
      mem_funct3_s = bus.core_funct3;
    end else if (gnt_s[HOST]) begin
      mem_we_s     = bus.host_we;
      mem_addr_s   = bus.host_addr;
      mem_wdata_s  = bus.host_wdata;
      mem_funct3_s = bus.host_funct3;
    end else begin
      mem_we_s     = 1'b0;
      mem_addr_s   = '0;
      mem_wdata_s  = '0;
      mem_funct3_s = 3'b000;
    end
  end

  // Loads that complete this cycle and will return data next cycle.
  always_comb begin
    core_load_s = gnt_s[CORE] && !bus.core_we;
    host_load_s = gnt_s[HOST] && !bus.host_we;
  end

  assign bus.core_gnt    = gnt_s[CORE];
  assign bus.host_gnt    = gnt_s[HOST];
  assign bus.core_stall  = req_s[CORE] && !gnt_s[CORE];
  assign bus.core_rvalid = core_rvalid_r;
  assign bus.core_rdata  = core_rdata_r;
  assign bus.host_rvalid = host_rvalid_r;
  assign bus.host_rdata  = host_rdata_r;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = mem_wdata_s;
  assign bus.mem_funct3  = mem_funct3_s;

  // Lock FSM, round-robin pointer and the read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_r  <= UNLOCKED;
      lock_cnt_r    <= CNT_ZRO;
      prio_r        <= 1'b0;
      core_rvalid_r <= 1'b0;
      host_rvalid_r <= 1'b0;
      core_rdata_r  <= '0;
      host_rdata_r  <= '0;
    end else begin
      core_rvalid_r <= core_load_s;
      host_rvalid_r <= host_load_s;
      if (core_load_s) begin
        core_rdata_r <= bus.mem_rdata;
      end
      if (host_load_s) begin
        host_rdata_r <= bus.mem_rdata;
      end

      case (lock_state_r)
        UNLOCKED: begin
          // After a contended grant the loser gets priority next time.
          if (contended_s) begin
            prio_r <= gnt_s[CORE];
          end
          if (gnt_s[HOST] && bus.host_lock) begin
            lock_state_r <= LOCKED;
            lock_cnt_r   <= CNT_ONE;
          end else begin
            lock_state_r <= UNLOCKED;
            lock_cnt_r   <= CNT_ZRO;
          end
        end
        LOCKED: begin
          if (!bus.host_lock) begin
            lock_state_r <= UNLOCKED;
            lock_cnt_r   <= CNT_ZRO;
            prio_r       <= 1'b0;
          end else if (forced_s) begin
            lock_cnt_r   <= CNT_ZRO;
          end else if (gnt_s[HOST]) begin
            lock_cnt_r   <= cnt_inc_s;
          end
        end
        default: begin
          lock_state_r <= UNLOCKED;
          lock_cnt_r   <= CNT_ZRO;
          prio_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule
